// File: rtl/instr_pkg.sv
// Shared definitions for the instruction encoder/loader: formats, field layout,
// opcode constants, the legal-opcode set and the word encoder.
package instr_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'd0,
        FMT_I   = 2'd1,
        FMT_JI  = 2'd2,
        FMT_JII = 2'd3
    } fmt_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2
    } ld_state_e;

    localparam int INSTR_W   = 32;
    localparam int OPC_W     = 5;
    localparam int REG_W     = 5;
    localparam int IMM_W     = 17;
    localparam int TGT_W     = 27;
    localparam int OPC_LSB   = 27;
    localparam int RD_LSB    = 22;
    localparam int RS_LSB    = 17;
    localparam int RT_LSB    = 12;
    localparam int SHAMT_LSB = 7;
    localparam int ALU_LSB   = 2;

    localparam logic [OPC_W-1:0] OP_R    = 5'b00000;
    localparam logic [OPC_W-1:0] OP_J    = 5'b00001;
    localparam logic [OPC_W-1:0] OP_BNE  = 5'b00010;
    localparam logic [OPC_W-1:0] OP_JAL  = 5'b00011;
    localparam logic [OPC_W-1:0] OP_JR   = 5'b00100;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OPC_W-1:0] OP_BLT  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_SW   = 5'b00111;
    localparam logic [OPC_W-1:0] OP_LW   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_SETX = 5'b10101;
    localparam logic [OPC_W-1:0] OP_BEX  = 5'b10110;

    function automatic logic is_legal_opcode(input logic [OPC_W-1:0] op);
        case (op)
            OP_R, OP_J, OP_BNE, OP_JAL, OP_JR, OP_ADDI,
            OP_BLT, OP_SW, OP_LW, OP_SETX, OP_BEX: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic [INSTR_W-1:0] encode_instr(
        input fmt_e             fmt,
        input logic [OPC_W-1:0] opcode,
        input logic [REG_W-1:0] rd,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [REG_W-1:0] shamt,
        input logic [REG_W-1:0] alu_op,
        input logic [IMM_W-1:0] imm,
        input logic [TGT_W-1:0] target
    );
        logic [INSTR_W-1:0] w;
        w = '0;
        w[OPC_LSB +: OPC_W] = opcode;
        case (fmt)
            FMT_R: begin
                w[RD_LSB    +: REG_W] = rd;
                w[RS_LSB    +: REG_W] = rs;
                w[RT_LSB    +: REG_W] = rt;
                w[SHAMT_LSB +: REG_W] = shamt;
                w[ALU_LSB   +: REG_W] = alu_op;
            end
            FMT_I: begin
                w[RD_LSB +: REG_W] = rd;
                w[RS_LSB +: REG_W] = rs;
                w[0      +: IMM_W] = imm;
            end
            FMT_JI:  w[0 +: TGT_W] = target;
            default: w[RD_LSB +: REG_W] = rd;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO holding encoded words paired with their write addresses.
// Head outputs read as zero while empty.
module instr_fifo #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic              pop,
    output logic              empty,
    output logic              full,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; emptying the pointers is enough
    // and the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push) begin
            data_mem[wr_ptr] <= push_data;
            addr_mem[wr_ptr] <= push_addr;
        end
    end

    assign head_data = empty ? '0 : data_mem[rd_ptr];
    assign head_addr = empty ? '0 : addr_mem[rd_ptr];

endmodule

// File: rtl/instr_encoder_loader.sv
// Encodes instruction fields into 32-bit words and streams them with sequential
// load addresses. Define OPCODE_CHECK_EN to drop illegal opcodes and flag err.
module instr_encoder_loader
    import instr_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [1:0]        fmt,
    input  logic [4:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        shamt,
    input  logic [4:0]        alu_op,
    input  logic [16:0]       imm,
    input  logic [26:0]       target,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt;
    logic [31:0]       encoded;
    logic              fifo_empty, fifo_full;
    logic              accept, push, op_ok, launch;

`ifdef OPCODE_CHECK_EN
    assign op_ok = is_legal_opcode(opcode);
`else
    assign op_ok = 1'b1;
`endif

    assign accept  = in_valid && in_ready;
    assign push    = accept && op_ok;
    assign launch  = (state_q == IDLE) && start;
    assign encoded = encode_instr(fmt_e'(fmt), opcode, rd, rs, rt, shamt, alu_op, imm, target);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the combinational block below uses blocking ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE:   if (start) state_d = ACTIVE;
            ACTIVE: begin
                in_ready = !fifo_full;
                if (in_valid && !fifo_full && in_last) state_d = DRAIN;
            end
            DRAIN: begin
                if (fifo_empty) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    addr_cnt <= '0;
        else if (launch) addr_cnt <= base_addr;
        else if (push)   addr_cnt <= addr_cnt + 1'b1;
    end

`ifdef OPCODE_CHECK_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)              err <= 1'b0;
        else if (launch)           err <= 1'b0;
        else if (accept && !op_ok) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    assign busy      = (state_q != IDLE);
    assign out_valid = !fifo_empty;

    instr_fifo #(
        .DATA_W (32),
        .ADDR_W (ADDR_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (encoded),
        .push_addr (addr_cnt),
        .pop       (out_valid && out_ready),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .head_data (out_data),
        .head_addr (out_addr)
    );

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader: directed vectors plus random sessions
// against a field-arithmetic reference model.
module tb_instr_encoder_loader;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_last = 1'b0;
    logic [1:0]  fmt = '0;
    logic [4:0]  opcode = '0, rd = '0, rs = '0, rt = '0, shamt = '0, alu_op = '0;
    logic [16:0] imm = '0;
    logic [26:0] target = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic [11:0] out_addr;
    logic        busy, done, err;

    int          tests = 0;
    int          fails = 0;
    int          cycle = 0;
    logic [31:0] sb_data [$];
    logic [11:0] sb_addr [$];
    int          xfer_cyc [$];
    logic [11:0] m_addr = '0;
    logic        err_exp = 1'b0;
    logic        rand_ready = 1'b0;
    logic        hold_pending = 1'b0;
    logic [31:0] hold_d;
    logic [11:0] hold_a;

    instr_encoder_loader #(.ADDR_W(12), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .fmt(fmt),
        .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .shamt(shamt), .alu_op(alu_op),
        .imm(imm), .target(target), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    always @(posedge clock) begin
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model_legal(input logic [4:0] op);
`ifdef OPCODE_CHECK_EN
        return op inside {5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22};
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [31:0] model_encode(input int f, input int op, input int r_d,
        input int r_s, input int r_t, input int sh, input int alu, input int im, input int tg);
        case (f)
            0:       return 32'(op * 2**27 + r_d * 2**22 + r_s * 2**17 + r_t * 2**12 + sh * 2**7 + alu * 4);
            1:       return 32'(op * 2**27 + r_d * 2**22 + r_s * 2**17 + im);
            2:       return 32'(op * 2**27 + tg);
            default: return 32'(op * 2**27 + r_d * 2**22);
        endcase
    endfunction

    // Monitor: compares every transfer against the scoreboard and checks hold stability.
    always @(negedge clock) begin
        if (!reset_n) begin
            hold_pending = 1'b0;
        end else begin
            if (hold_pending && out_valid) begin
                check("hold out_data", out_data, hold_d);
                check("hold out_addr", out_addr, hold_a);
            end
            hold_pending = out_valid && !out_ready;
            hold_d = out_data;
            hold_a = out_addr;
            if (out_valid && out_ready) begin
                xfer_cyc.push_back(cycle);
                if (sb_data.size() == 0) begin
                    check("unexpected output", 1, 0);
                end else begin
                    check("out_data", out_data, sb_data.pop_front());
                    check("out_addr", out_addr, sb_addr.pop_front());
                end
            end
        end
    end

    task automatic begin_session(input logic [11:0] b);
        start = 1'b1;
        base_addr = b;
        @(posedge clock); #1;
        start = 1'b0;
        m_addr = b;
        err_exp = 1'b0;
    endtask

    task automatic beat(input int f, input int op, input int r_d, input int r_s, input int r_t,
        input int sh, input int alu, input int im, input int tg, input logic last);
        bit ok = 0;
        fmt = 2'(f); opcode = 5'(op); rd = 5'(r_d); rs = 5'(r_s); rt = 5'(r_t);
        shamt = 5'(sh); alu_op = 5'(alu); imm = 17'(im); target = 27'(tg);
        in_last = last;
        in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clock);
            if (in_ready) begin
                ok = 1;
                if (model_legal(5'(op))) begin
                    sb_data.push_back(model_encode(f, op, r_d, r_s, r_t, sh, alu, im, tg));
                    sb_addr.push_back(m_addr);
                    m_addr = m_addr + 1'b1;
                end else begin
                    err_exp = 1'b1;
                end
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        if (!ok) check("beat accept timeout", 0, 1);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clock);
            if (done) seen = 1;
        end
        check("done pulse seen", seen, 1);
        if (seen) begin
            check("outstanding at done", sb_data.size(), 0);
            @(negedge clock);
            check("done one cycle", done, 0);
            check("busy after done", busy, 0);
            check("err after session", err, err_exp);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #3;
        check("rst in_ready", in_ready, 0);
        check("rst out_valid", out_valid, 0);
        check("rst out_data", out_data, 0);
        check("rst out_addr", out_addr, 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst err", err, 0);
        @(posedge clock); @(posedge clock); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clock); #1;

        // Single R-format word.
        begin_session(12'h010);
        check("busy in session", busy, 1);
        beat(0, 0, 3, 1, 2, 0, 0, 0, 0, 1'b1);
        wait_done();

        // Back-to-back I, JI, JII with continuous drain.
        xfer_cyc.delete();
        begin_session(12'h020);
        beat(1, 5, 1, 0, 0, 0, 0, 5, 0, 1'b0);
        beat(2, 1, 0, 0, 0, 0, 0, 0, 100, 1'b0);
        beat(3, 4, 31, 0, 0, 0, 0, 0, 0, 1'b1);
        wait_done();
        check("xfer count b2b", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            check("b2b spacing 1", xfer_cyc[1] - xfer_cyc[0], 1);
            check("b2b spacing 2", xfer_cyc[2] - xfer_cyc[1], 1);
        end

        // Stalled output: only four beats fit.
        out_ready = 1'b0;
        begin_session(12'h100);
        for (int k = 0; k < 4; k++) beat(1, 5, k, k + 1, 0, 0, 0, 17'h1_0000 + k, 0, 1'b0);
        fmt = 2'd0; opcode = 5'd0; rd = 5'd9; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("full in_ready", in_ready, 0);
            check("full out_valid", out_valid, 1);
            @(posedge clock); #1;
        end
        out_ready = 1'b1;
        beat(0, 0, 9, 0, 0, 0, 0, 0, 0, 1'b1);
        wait_done();

        // Address wrap.
        begin_session(12'hFFF);
        beat(2, 3, 0, 0, 0, 0, 0, 0, 27'h7FF_FFFF, 1'b0);
        beat(3, 2, 7, 0, 0, 0, 0, 0, 0, 1'b1);
        wait_done();

        // Illegal opcode between two legal words.
        begin_session(12'h200);
        beat(1, 7, 2, 3, 0, 0, 0, 99, 0, 1'b0);
        beat(0, 31, 1, 1, 1, 1, 1, 0, 0, 1'b0);
        beat(1, 8, 4, 5, 0, 0, 0, 7, 0, 1'b1);
        wait_done();
        begin_session(12'h300);
        check("err cleared by start", err, 0);
        beat(0, 0, 1, 2, 3, 4, 5, 0, 0, 1'b1);
        wait_done();

        // Reset with three words buffered.
        out_ready = 1'b0;
        begin_session(12'h040);
        for (int k = 0; k < 3; k++) beat(3, 4, k, 0, 0, 0, 0, 0, 0, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("mid-rst out_valid", out_valid, 0);
        check("mid-rst busy", busy, 0);
        check("mid-rst out_data", out_data, 0);
        sb_data.delete();
        sb_addr.delete();
        @(posedge clock); #1;
        reset_n = 1'b1;
        out_ready = 1'b1;
        fmt = 2'd1; opcode = 5'd5; in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check("post-rst in_ready", in_ready, 0);
            check("post-rst out_valid", out_valid, 0);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;

        // Random sessions with random back-pressure.
        rand_ready = 1'b1;
        for (int s = 0; s < 30; s++) begin
            int len;
            len = $urandom_range(1, 7);
            begin_session(12'($urandom));
            for (int b = 0; b < len; b++) begin
                int op;
                op = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 31))
                                                 : int'($urandom_range(0, 8));
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clock); #1;
                end
                beat($urandom_range(0, 3), op, $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                     $urandom_range(0, 17'h1FFFF), $urandom_range(0, 27'h7FFFFFF), b == len - 1);
            end
            wait_done();
        end
        rand_ready = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got %0d cycles expected fewer", cycle);
        $fatal(1, "watchdog");
    end

endmodule
